serial_word_rx: RTL and testbench
=================================

# serial_word_rx

Serial receiver that turns an 8N1 UART byte stream on `srx` into 32-bit words for the programmer's command/data path. It sits directly upstream of the programmer FSM, which consumes `rx_word` on each `ready` pulse. Four bytes are assembled per word, first byte most significant. A partial word is discarded if the gap between bytes exceeds the inter-byte timeout.

## Interface
- `CLK_RATE`, default -1 (must be overridden): clk rate in MHz.
- `BAUD`, default 115200: serial bit rate in bits/s.
- `IB_TIMEOUT`, default 200: max idle gap between bytes of one word, in ms.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `srx`  in  1  asynchronous serial input; idle high.
- `ready`  out  1  one-cycle pulse: a complete word is on `rx_word`.
- `rx_word`  out  32  last completed word; held until the next word completes.
- `frame_err`  out  1  one-cycle pulse: a stop bit sampled low.

## Operation
- Derived constants (integer arithmetic):
  - BIT_CLKS = CLK_RATE*1_000_000/BAUD.
  - HALF = BIT_CLKS/2.
  - IB_CLKS = CLK_RATE*IB_TIMEOUT*1000.
- `srx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `srx_s`.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when `srx_s`==0; the bit-timer clears.
  - START: wait HALF cycles, then sample. If the sample is 1 it is a glitch: go to IDLE, no byte, no error. If 0, go to DATA.
  - DATA: sample every BIT_CLKS cycles, 8 bits, LSB first, into a byte register. After the 8th sample, go to STOP.
  - STOP: sample after BIT_CLKS. If 1, the byte is valid. If 0, pulse `frame_err`, clear the byte count (partial word dropped), and drop the byte. Go to IDLE either way; the remaining half stop bit is not waited out.
  - After a framing error, IDLE will not re-trigger until `srx_s` has been seen high at least once.
- Word assembly:
  - 2-bit byte count and 24-bit shift register.
  - Valid byte with count<3: shift left 8, insert the byte, count+1.
  - Valid byte with count==3: `rx_word` <= {shreg[23:0], byte}, pulse `ready`, count <= 0.
- Inter-byte timeout:
  - The counter increments only while the FSM is in IDLE and count!=0.
  - It clears when a start edge is accepted and whenever count==0.
  - On reaching IB_CLKS: count <= 0, partial bytes discarded, counter cleared. No pulse on any output.
- `rx_word` is never modified except on a `ready` cycle. No payload check is performed here; byte-XOR validation belongs to the consumer.

## Timing
- Reset values: `ready`=0, `frame_err`=0, `rx_word`=0, FSM=IDLE, count=0, timers=0, sync flops=1.
- Let t0 be the first cycle with `srx_s`==0 in IDLE.
  - Start sample: t0+HALF.
  - Data bit i (0..7): t0+HALF+(i+1)*BIT_CLKS.
  - Stop sample: t0+HALF+9*BIT_CLKS.
- `ready` or `frame_err` is high on the cycle after the stop sample, for exactly 1 cycle. `rx_word` is valid in the same cycle as `ready` and stays valid afterwards.
- Back-to-back bytes with no idle time are supported: the next falling edge is detected at the latest at the byte boundary.
- If a timeout and a start edge occur in the same cycle, the timeout is applied first. The new byte becomes byte 0 of a fresh word.
- Reset asserted mid-byte or mid-word: everything returns to reset values immediately. No `ready` is produced for the interrupted word.
- Counter widths are $clog2(limit+1). Counters saturate/clear as specified and never wrap.

## Test plan
Common parameters: CLK_RATE=10, BAUD=1_000_000 (BIT_CLKS=10), IB_TIMEOUT=1 (IB_CLKS=10000).
- Send bytes 0x0F, 0xF0, 0x00, 0xFF back-to-back. Required: a single `ready` pulse with `rx_word`=0x0FF000FF, 1 cycle after the 4th stop sample; `frame_err` stays 0.
- Send two words, 0x12345678 then 0xDEADBEEF, with 3 idle bit-times between bytes. Required: two `ready` pulses. `rx_word` holds 0x12345678 between them, then 0xDEADBEEF.
- Send 2 bytes, idle 12000 cycles, then send 0xAA, 0xBB, 0xCC, 0xDD. Required: one `ready` only, with `rx_word`=0xAABBCCDD.
- Send a 3-cycle low glitch on `srx`. Required: no `ready`, no `frame_err`; a following full word is received correctly.
- Send byte 0x55 with its stop bit low, then a full word 0x01020304. Required: a `frame_err` pulse 1 cycle after the bad stop sample; then `ready` with 0x01020304.
- Assert `rst` during the 3rd byte, release, then send 0xCAFEF00D. Required: outputs at reset values during reset; exactly one `ready` afterwards, with 0xCAFEF00D.

Source files
------------

// File: rtl/serial_word_rx.sv
// 8N1 serial receiver that packs four bytes (first byte most significant) into a 32-bit word.
// A partial word is dropped on a framing error or when the gap between its bytes grows too long.
module serial_word_rx #(
   parameter int CLK_RATE   = -1,
   parameter int BAUD       = 115200,
   parameter int IB_TIMEOUT = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        srx,
   output logic        ready,
   output logic [31:0] rx_word,
   output logic        frame_err
);

   localparam int BIT_RAW  = CLK_RATE * 1_000_000 / BAUD;
   // Clamp so an unconfigured instance still elaborates with legal counter widths.
   localparam int BIT_CLKS = (BIT_RAW < 2) ? 2 : BIT_RAW;
   localparam int HALF     = BIT_CLKS / 2;
   localparam int IB_RAW   = CLK_RATE * IB_TIMEOUT * 1000;
   localparam int IB_CLKS  = (IB_RAW < 1) ? 1 : IB_RAW;
   localparam int TW       = $clog2(BIT_CLKS + 1);
   localparam int IW       = $clog2(IB_CLKS + 1);

   localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CLKS - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
   localparam logic [IW-1:0] IB_LIMIT  = IW'(IB_CLKS);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic          sync1;
   logic          srx_s;
   logic          armed;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    rx_byte;
   logic [23:0]   shreg;
   logic [1:0]    word_cnt;
   logic [IW-1:0] ib_cnt;
   logic          start_ok;
   logic          ib_hit;

   assign start_ok = (state == IDLE) && !srx_s && armed;
   assign ib_hit   = (ib_cnt == IB_LIMIT);

   // Two-flop synchronizer for the asynchronous serial line, idling high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         srx_s <= 1'b1;
      end else begin
         sync1 <= srx;
         srx_s <= sync1;
      end
   end

   // Byte FSM, word assembly and inter-byte timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         armed     <= 1'b1;
         timer     <= '0;
         bit_idx   <= 3'd0;
         rx_byte   <= 8'h00;
         shreg     <= 24'h000000;
         word_cnt  <= 2'd0;
         ib_cnt    <= '0;
         ready     <= 1'b0;
         frame_err <= 1'b0;
         rx_word   <= 32'h0000_0000;
      end else begin
         ready     <= 1'b0;
         frame_err <= 1'b0;

         // Timeout wins over a simultaneous start edge: the new byte opens a fresh word.
         if (ib_hit) begin
            word_cnt <= 2'd0;
         end
         if (ib_hit || word_cnt == 2'd0 || start_ok) begin
            ib_cnt <= '0;
         end else if (state == IDLE) begin
            ib_cnt <= ib_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (srx_s) begin
                  armed <= 1'b1;
               end
               if (start_ok) begin
                  state <= START;
                  timer <= '0;
               end
            end
            START: begin
               if (timer == HALF_LAST) begin
                  timer   <= '0;
                  bit_idx <= 3'd0;
                  state   <= srx_s ? IDLE : DATA;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DATA: begin
               if (timer == BIT_LAST) begin
                  timer   <= '0;
                  rx_byte <= {srx_s, rx_byte[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            STOP: begin
               if (timer == BIT_LAST) begin
                  timer <= '0;
                  state <= IDLE;
                  if (srx_s) begin
                     if (word_cnt == 2'd3) begin
                        rx_word  <= {shreg, rx_byte};
                        ready    <= 1'b1;
                        word_cnt <= 2'd0;
                     end else begin
                        shreg    <= {shreg[15:0], rx_byte};
                        word_cnt <= word_cnt + 2'd1;
                     end
                  end else begin
                     // Line still low: wait for it to go high before hunting for a start bit.
                     frame_err <= 1'b1;
                     word_cnt  <= 2'd0;
                     armed     <= 1'b0;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: 10 MHz clock, 1 Mbit/s line (10 clocks per bit),
// 1 ms inter-byte timeout (10000 clocks).
module tb_serial_word_rx;

   logic        clk;
   logic        rst;
   logic        srx;
   logic        ready;
   logic [31:0] rx_word;
   logic        frame_err;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_start = 0;
   int ready_cnt = 0;
   int ferr_cnt = 0;
   int ready_cyc = -1;
   int ferr_cyc = -1;

   serial_word_rx #(.CLK_RATE(10), .BAUD(1_000_000), .IB_TIMEOUT(1)) dut (
      .clk(clk),
      .rst(rst),
      .srx(srx),
      .ready(ready),
      .rx_word(rx_word),
      .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         ready_cnt = ready_cnt + 1;
         ready_cyc = cyc;
      end
      if (frame_err === 1'b1) begin
         ferr_cnt = ferr_cnt + 1;
         ferr_cyc = cyc;
      end
   end

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      srx = 1'b1;
      wait_cycles(n);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      last_start = cyc;
      srx = 1'b0;
      wait_cycles(10);
      for (int i = 0; i < 8; i++) begin
         srx = b[i];
         wait_cycles(10);
      end
      srx = stop;
      wait_cycles(10);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 3; k >= 0; k--) begin
         send_byte(w[8*k +: 8], 1'b1);
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      srx = 1'b1;
      wait_cycles(3);
      n_vec++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
      n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      n_vec++; if (rx_word !== 32'h0000_0000) begin n_bad++; $display("FAIL reset_rx_word: got %h expected 00000000", rx_word); end
      rst = 1'b1;
      idle(5);
   endtask

   task automatic test_back_to_back;
      int r0, f0;
      r0 = ready_cnt; f0 = ferr_cnt;
      send_byte(8'h0F, 1'b1);
      send_byte(8'hF0, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      idle(5);
      n_vec++; if (ready_cnt - r0 !== 1) begin n_bad++; $display("FAIL b2b_ready_count: got %0d expected 1", ready_cnt - r0); end
      n_vec++; if (rx_word !== 32'h0FF0_00FF) begin n_bad++; $display("FAIL b2b_rx_word: got %h expected 0ff000ff", rx_word); end
      n_vec++; if (ready_cyc !== last_start + 98) begin n_bad++; $display("FAIL b2b_ready_cycle: got %0d expected %0d", ready_cyc, last_start + 98); end
      n_vec++; if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL b2b_frame_err: got %0d expected 0", ferr_cnt - f0); end
   endtask

   task automatic test_two_words;
      int r0;
      r0 = ready_cnt;
      send_word(32'h1234_5678, 30);
      n_vec++; if (ready_cnt - r0 !== 1) begin n_bad++; $display("FAIL word1_ready_count: got %0d expected 1", ready_cnt - r0); end
      n_vec++; if (rx_word !== 32'h1234_5678) begin n_bad++; $display("FAIL word1_rx_word: got %h expected 12345678", rx_word); end
      send_byte(8'hDE, 1'b1);
      idle(30);
      send_byte(8'hAD, 1'b1);
      idle(30);
      n_vec++; if (rx_word !== 32'h1234_5678) begin n_bad++; $display("FAIL word1_hold: got %h expected 12345678", rx_word); end
      send_byte(8'hBE, 1'b1);
      idle(30);
      send_byte(8'hEF, 1'b1);
      idle(30);
      n_vec++; if (ready_cnt - r0 !== 2) begin n_bad++; $display("FAIL word2_ready_count: got %0d expected 2", ready_cnt - r0); end
      n_vec++; if (rx_word !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL word2_rx_word: got %h expected deadbeef", rx_word); end
   endtask

   task automatic test_timeout;
      int r0;
      r0 = ready_cnt;
      send_byte(8'h99, 1'b1);
      send_byte(8'h88, 1'b1);
      idle(12000);
      send_word(32'hAABB_CCDD, 30);
      n_vec++; if (ready_cnt - r0 !== 1) begin n_bad++; $display("FAIL timeout_ready_count: got %0d expected 1", ready_cnt - r0); end
      n_vec++; if (rx_word !== 32'hAABB_CCDD) begin n_bad++; $display("FAIL timeout_rx_word: got %h expected aabbccdd", rx_word); end
   endtask

   task automatic test_glitch;
      int r0, f0;
      r0 = ready_cnt; f0 = ferr_cnt;
      srx = 1'b0;
      wait_cycles(3);
      idle(50);
      n_vec++; if (ready_cnt - r0 !== 0) begin n_bad++; $display("FAIL glitch_ready: got %0d expected 0", ready_cnt - r0); end
      n_vec++; if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL glitch_frame_err: got %0d expected 0", ferr_cnt - f0); end
      send_word(32'h89AB_CDEF, 20);
      n_vec++; if (ready_cnt - r0 !== 1) begin n_bad++; $display("FAIL glitch_word_count: got %0d expected 1", ready_cnt - r0); end
      n_vec++; if (rx_word !== 32'h89AB_CDEF) begin n_bad++; $display("FAIL glitch_rx_word: got %h expected 89abcdef", rx_word); end
   endtask

   task automatic test_frame_err;
      int r0, f0, bad_start;
      r0 = ready_cnt; f0 = ferr_cnt;
      send_byte(8'h77, 1'b1);
      idle(20);
      send_byte(8'h55, 1'b0);
      bad_start = last_start;
      idle(30);
      n_vec++; if (ferr_cnt - f0 !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
      n_vec++; if (ferr_cyc !== bad_start + 98) begin n_bad++; $display("FAIL ferr_cycle: got %0d expected %0d", ferr_cyc, bad_start + 98); end
      n_vec++; if (ready_cnt - r0 !== 0) begin n_bad++; $display("FAIL ferr_no_ready: got %0d expected 0", ready_cnt - r0); end
      send_word(32'h0102_0304, 20);
      n_vec++; if (ready_cnt - r0 !== 1) begin n_bad++; $display("FAIL ferr_word_count: got %0d expected 1", ready_cnt - r0); end
      n_vec++; if (rx_word !== 32'h0102_0304) begin n_bad++; $display("FAIL ferr_rx_word: got %h expected 01020304", rx_word); end
      n_vec++; if (ferr_cnt - f0 !== 1) begin n_bad++; $display("FAIL ferr_single: got %0d expected 1", ferr_cnt - f0); end
   endtask

   task automatic test_reset_mid;
      int r0;
      r0 = ready_cnt;
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      srx = 1'b0;
      wait_cycles(10);
      srx = 1'b1;
      wait_cycles(20);
      rst = 1'b0;
      wait_cycles(3);
      n_vec++; if (ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b expected 0", ready); end
      n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_frame_err: got %b expected 0", frame_err); end
      n_vec++; if (rx_word !== 32'h0000_0000) begin n_bad++; $display("FAIL midrst_rx_word: got %h expected 00000000", rx_word); end
      rst = 1'b1;
      idle(30);
      send_word(32'hCAFE_F00D, 20);
      n_vec++; if (ready_cnt - r0 !== 1) begin n_bad++; $display("FAIL midrst_ready_count: got %0d expected 1", ready_cnt - r0); end
      n_vec++; if (rx_word !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL midrst_rx_word_after: got %h expected cafef00d", rx_word); end
   endtask

   initial begin
      rst = 1'b0;
      srx = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_back_to_back();
      test_two_words();
      test_timeout();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
